// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the round-robin ALU scheduler and its ALU.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: data/opcode widths, opcode encodings OP_ADD..OP_SHR, FSM state
// encoding ST_IDLE/ST_EXEC/ST_RESP.
package alu_pkg;

  // Datapath width of the shared ALU.
  localparam int ALU_W = 4;
  // Opcode width.
  localparam int OP_W  = 3;

  // Opcodes.
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  // Scheduler FSM encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu.sv
// alu: combinational ALU_W-bit ALU (add/sub/logic/shift) with carry and zero flags.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: a, b (operands), op (opcode), y (result), cout (carry, or borrow for SUB),
// zero (y == 0).
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [ALU_W-1:0] y,
  output logic             cout,
  output logic             zero
);

  // One extra bit on top so ADD carry and SUB borrow fall out of the same
  // ALU_W+1 bit result; logic and shift ops leave it clear.
  logic [ALU_W:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      // Unsigned 5-bit subtraction: top bit is set exactly when a < b.
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_NOT:  wide = {1'b0, ~a};
      OP_SHL:  wide = {1'b0, a[ALU_W-2:0], 1'b0};
      OP_SHR:  wide = {2'b00, a[ALU_W-1:1]};
      default: wide = '0;
    endcase
  end

  assign y    = wide[ALU_W-1:0];
  assign cout = wide[ALU_W];
  assign zero = (wide[ALU_W-1:0] == '0);

endmodule

// File: rtl/alu_rr_sched.sv
// alu_rr_sched: round-robin scheduler sharing one ALU among NREQ requesters, id-tagged response.
// Latency: accept edge -> EXEC cycle -> response registered on the next edge; max 1 op / 3 cycles.
// Backpressure: response held stable until rsp_ready; no new grant until the response is taken.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   per-requester handshake (req_ready one-hot or zero, IDLE only)
//   req_a/req_b           packed operands, requester i at [4i+3:4i]
//   req_op                packed opcodes, requester i at [3i+2:3i]
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_y/rsp_cout/rsp_zero  response payload
//
// Configuration macro: ALU_SCHED_PRIO_EN -- requester 0 wins whenever it is
// valid in IDLE and its grants leave the round-robin pointer untouched.
// Without it all requesters are served in pure round-robin order.
module alu_rr_sched
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ALU_W-1:0] req_a,
  input  logic [NREQ*ALU_W-1:0] req_b,
  input  logic [NREQ*OP_W-1:0]  req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_y,
  output logic                  rsp_cout,
  output logic                  rsp_zero
);

  // NREQ at the width used for modular pointer arithmetic.
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW:0] ONE_W  = (IDW+1)'(1);

  logic [1:0]       state;
  logic [IDW-1:0]   ptr;

  // Operands captured at the grant handshake; the ALU only ever sees these,
  // so requesters may change their inputs as soon as they are accepted.
  logic [ALU_W-1:0] lat_a;
  logic [ALU_W-1:0] lat_b;
  logic [OP_W-1:0]  lat_op;
  logic [IDW-1:0]   lat_id;

  logic [ALU_W-1:0] alu_y;
  logic             alu_cout;
  logic             alu_zero;

  // ---------------------------------------------------------------------
  // Arbiter: rotate req_valid so ptr lands at bit 0, find first set bit,
  // then add ptr back (mod NREQ) to get the absolute requester index.
  // ---------------------------------------------------------------------
  logic             any_req;
  logic [IDW-1:0]   gnt_id;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]  rot;
  logic [IDW-1:0]   ofs;
  logic             found;
  logic [IDW:0]     gsum;

  always_comb begin
    any_req = |req_valid;
    dbl     = {req_valid, req_valid} >> ptr;
    rot     = dbl[NREQ-1:0];
    found   = 1'b0;
    ofs     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        ofs   = IDW'(i);
      end
    end
    gsum = {1'b0, ptr} + {1'b0, ofs};
    if (gsum >= NREQ_W) begin
      gsum = gsum - NREQ_W;
    end
    gnt_id = gsum[IDW-1:0];
`ifdef ALU_SCHED_PRIO_EN
    // Requester 0 overrides the rotation whenever it is asking.
    if (req_valid[0]) begin
      gnt_id = '0;
    end
`endif
  end

  // Grant is offered only in IDLE and only while out of reset; with a valid
  // request present the handshake always completes on this edge.
  always_comb begin
    req_ready = '0;
    if (!rst && state == ST_IDLE && any_req) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  // Select the granted requester's operands for latching.
  logic [ALU_W-1:0] sel_a;
  logic [ALU_W-1:0] sel_b;
  logic [OP_W-1:0]  sel_op;

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IDW'(i)) begin
        sel_a  = req_a[i*ALU_W +: ALU_W];
        sel_b  = req_b[i*ALU_W +: ALU_W];
        sel_op = req_op[i*OP_W +: OP_W];
      end
    end
  end

  // Pointer advances to the requester after the one just served, wrapping.
  logic [IDW:0]   psum;
  logic [IDW-1:0] ptr_nxt;

  always_comb begin
    psum = {1'b0, lat_id} + ONE_W;
    if (psum >= NREQ_W) begin
      psum = '0;
    end
    ptr_nxt = psum[IDW-1:0];
  end

  // ---------------------------------------------------------------------
  // Shared ALU, fed only from the latched operands.
  // ---------------------------------------------------------------------
  alu u_alu (
    .a    (lat_a),
    .b    (lat_b),
    .op   (lat_op),
    .y    (alu_y),
    .cout (alu_cout),
    .zero (alu_zero)
  );

  // ---------------------------------------------------------------------
  // FSM: IDLE (arbitrate/accept) -> EXEC (compute) -> RESP (hold result).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_op    <= '0;
      lat_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
      rsp_cout  <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            lat_a  <= sel_a;
            lat_b  <= sel_b;
            lat_op <= sel_op;
            lat_id <= gnt_id;
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_y     <= alu_y;
          rsp_cout  <= alu_cout;
          rsp_zero  <= alu_zero;
          rsp_id    <= lat_id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
`ifdef ALU_SCHED_PRIO_EN
            // Priority grants to requester 0 do not disturb the rotation.
            if (lat_id != '0) begin
              ptr <= ptr_nxt;
            end
`else
            ptr <= ptr_nxt;
`endif
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
